pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register with a two-entry skid buffer and a valid/ready handshake. It carries one instruction bundle between adjacent CPU pipeline stages: instruction word, PC, exception code and branch-delay flag. It replaces fixed stall-and-hold stage registers, so the upstream stage can keep issuing for one cycle after downstream backpressure. A flush (exception, eret) empties it in one cycle.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_slot.sv | 66 ++++++
 rtl/pipe_skid_stage.sv | 135 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: exception codes,
// the NOP encoding, the default bundle layout and the occupancy states.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_W   = 32;
    localparam int DEF_EXC_W  = 5;

    localparam logic [DEF_EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [DEF_EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [DEF_EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [DEF_EXC_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [DEF_EXC_W-1:0] EXC_BP   = 5'd9;
    localparam logic [DEF_EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [DEF_EXC_W-1:0] EXC_OV   = 5'd12;

    localparam logic [DEF_DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_EXC_W-1:0]  exc;
        logic                  bd;
    } bundle_t;

    // Occupancy doubles as the control state; the encoding is the entry count.
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_TWO   = 2'd2
    } count_e;

endpackage

// File: rtl/pipe_slot.sv
// One bundle register. Clear wins over load so an emptied slot always reads
// back as a NOP bubble with no exception.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int EXC_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_instr,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [EXC_W-1:0]  d_exc,
    input  logic              d_bd,
    output logic [DATA_W-1:0] q_instr,
    output logic [PC_W-1:0]   q_pc,
    output logic [EXC_W-1:0]  q_exc,
    output logic              q_bd
);

    logic [DATA_W-1:0] instr_d, instr_q;
    logic [PC_W-1:0]   pc_d, pc_q;
    logic [EXC_W-1:0]  exc_d, exc_q;
    logic              bd_d, bd_q;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        if (clear) begin
            instr_d = DATA_W'(NOP_INSTR);
            pc_d    = '0;
            exc_d   = '0;
            bd_d    = 1'b0;
        end else if (load) begin
            instr_d = d_instr;
            pc_d    = d_pc;
            exc_d   = d_exc;
            bd_d    = d_bd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            exc_q   <= '0;
            bd_q    <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
        end
    end

    assign q_instr = instr_q;
    assign q_pc    = pc_q;
    assign q_exc   = exc_q;
    assign q_bd    = bd_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a two-entry skid buffer between CPU stages.
// Handshake: a bundle moves on a rising edge where valid & ready are both high;
// in_ready/out_valid come from count_q only, never from the opposite side's inputs.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int EXC_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [1:0]        count
);

    count_e count_d, count_q;
    logic   accept, pop;
    logic   head_load, head_clr, head_from_skid;
    logic   skid_load, skid_clr;

    logic [DATA_W-1:0] skid_instr, head_d_instr;
    logic [PC_W-1:0]   skid_pc, head_d_pc;
    logic [EXC_W-1:0]  skid_exc, head_d_exc;
    logic              skid_bd, head_d_bd;

    assign in_ready  = (count_q != CNT_TWO);
    assign out_valid = (count_q != CNT_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        count_d        = count_q;
        head_load      = 1'b0;
        head_clr       = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            count_d  = CNT_EMPTY;
            head_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (count_q)
                CNT_EMPTY: begin
                    if (accept) begin
                        count_d   = CNT_ONE;
                        head_load = 1'b1;
                    end
                end
                CNT_ONE: begin
                    if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        count_d   = CNT_TWO;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        count_d  = CNT_EMPTY;
                        head_clr = 1'b1;
                    end
                end
                CNT_TWO: begin
                    if (pop) begin
                        count_d        = CNT_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    count_d  = CNT_EMPTY;
                    head_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) count_q <= CNT_EMPTY;
        else        count_q <= count_d;
    end

    // The head refills from the skid slot when draining TWO, else from upstream.
    always_comb begin
        head_d_instr = head_from_skid ? skid_instr : in_instr;
        head_d_pc    = head_from_skid ? skid_pc    : in_pc;
        head_d_exc   = head_from_skid ? skid_exc   : in_exc;
        head_d_bd    = head_from_skid ? skid_bd    : in_bd;
    end

    pipe_slot #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_head (
        .clk     (clk),
        .reset   (reset),
        .load    (head_load),
        .clear   (head_clr),
        .d_instr (head_d_instr),
        .d_pc    (head_d_pc),
        .d_exc   (head_d_exc),
        .d_bd    (head_d_bd),
        .q_instr (out_instr),
        .q_pc    (out_pc),
        .q_exc   (out_exc),
        .q_bd    (out_bd)
    );

    pipe_slot #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clr),
        .d_instr (in_instr),
        .d_pc    (in_pc),
        .d_exc   (in_exc),
        .d_bd    (in_bd),
        .q_instr (skid_instr),
        .q_pc    (skid_pc),
        .q_exc   (skid_exc),
        .q_bd    (skid_bd)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus randomized traffic, all
// checked against a FIFO-of-capacity-two reference held in a queue.
module tb_pipe_skid_stage;

    localparam int DW = 32;
    localparam int PW = 32;
    localparam int EW = 5;
    localparam int W  = DW + PW + EW + 1;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, in_bd;
    logic [DW-1:0] in_instr;
    logic [PW-1:0] in_pc;
    logic [EW-1:0] in_exc;
    logic          out_valid, out_ready, out_bd;
    logic [DW-1:0] out_instr;
    logic [PW-1:0] out_pc;
    logic [EW-1:0] out_exc;
    logic [1:0]    count;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    pipe_skid_stage #(.DATA_W(DW), .PC_W(PW), .EXC_W(EW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_exc    (in_exc),
        .in_bd     (in_bd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_exc   (out_exc),
        .out_bd    (out_bd),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_head();
        return (exp_q.size() != 0) ? exp_q[0] : '0;
    endfunction

    function automatic logic [W-1:0] dut_head();
        return {out_instr, out_pc, out_exc, out_bd};
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] instr, input logic [PW-1:0] pc,
                         input logic [EW-1:0] exc, input logic bd);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        in_exc   = exc;
        in_bd    = bd;
    endtask

    // Advance one clock: update the reference from the inputs seen at the edge,
    // then settle 1 time unit past the edge before anything is sampled.
    task automatic tick();
        bit acc, pp;
        acc = in_valid && (exp_q.size() < 2);
        pp  = (exp_q.size() != 0) && out_ready;
        if (!reset || flush) begin
            exp_q.delete();
        end else begin
            if (pp) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({in_instr, in_pc, in_exc, in_bd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 32'h3000 + 4 * i, 5'd0, 1'b0);
            tick();
            n_checks++;
            if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ctrl: count=%0d out_valid=%b in_ready=%b, required 0/0/1", count, out_valid, in_ready);
            end
            n_checks++;
            if (dut_head() !== '0) begin
                n_fail++;
                $display("FAIL reset_payload: got %h required 0", dut_head());
            end
        end
    endtask

    task automatic test_stream();
        logic [PW-1:0] pcs[3];
        pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
        reset = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0100_0000 + i, pcs[i], 5'd0, 1'b0);
            tick();
            n_checks++;
            if (out_pc !== pcs[i] || count !== 2'd1 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d: pc=%h count=%0d valid=%b, required %h/1/1", i, out_pc, count, out_valid, pcs[i]);
            end
        end
        drive(1'b0, '0, '0, '0, 1'b0);
        tick();
        n_checks++;
        if (count !== 2'd0 || dut_head() !== '0) begin
            n_fail++;
            $display("FAIL stream_drain: count=%0d head=%h, required 0/0", count, dut_head());
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0000, 32'h3000, 5'd0, 1'b0); tick();
        drive(1'b1, 32'hAAAA_0004, 32'h3004, 5'd0, 1'b0); tick();
        n_checks++;
        if (count !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h3000) begin
            n_fail++;
            $display("FAIL bp_fill: count=%0d in_ready=%b pc=%h, required 2/0/3000", count, in_ready, out_pc);
        end
        drive(1'b1, 32'hAAAA_0008, 32'h3008, 5'd0, 1'b0); tick();
        n_checks++;
        if (count !== 2'd2 || out_pc !== 32'h3000) begin
            n_fail++;
            $display("FAIL bp_hold: count=%0d pc=%h, required 2/3000", count, out_pc);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_pc !== 32'h3004 || count !== 2'd1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_pop1: pc=%h count=%0d in_ready=%b, required 3004/1/1", out_pc, count, in_ready);
        end
        tick();
        drive(1'b0, '0, '0, '0, 1'b0);
        n_checks++;
        if (out_pc !== 32'h3008 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_pop2: pc=%h valid=%b, required 3008/1", out_pc, out_valid);
        end
        tick();
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: count=%0d valid=%b, required 0/0", count, out_valid);
        end
    endtask

    task automatic test_accept_pop();
        out_ready = 1'b0;
        drive(1'b1, 32'hBBBB_0000, 32'h3000, 5'd0, 1'b0); tick();
        out_ready = 1'b1;
        drive(1'b1, 32'hBBBB_0004, 32'h3004, 5'd0, 1'b0); tick();
        n_checks++;
        if (count !== 2'd1 || out_pc !== 32'h3004 || out_instr !== 32'hBBBB_0004) begin
            n_fail++;
            $display("FAIL accept_pop: count=%0d pc=%h instr=%h, required 1/3004/bbbb0004", count, out_pc, out_instr);
        end
        drive(1'b0, '0, '0, '0, 1'b0); tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'hCCCC_0000, 32'h4100, 5'd0, 1'b0); tick();
        drive(1'b1, 32'hCCCC_0004, 32'h4104, 5'd0, 1'b0); tick();
        flush = 1'b1;
        drive(1'b1, 32'hCCCC_0180, 32'h4180, 5'd0, 1'b0); tick();
        flush = 1'b0;
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_instr !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: count=%0d valid=%b instr=%h in_ready=%b, required 0/0/0/1", count, out_valid, out_instr, in_ready);
        end
        drive(1'b1, 32'hCCCC_0200, 32'h4200, 5'd0, 1'b0); tick();
        drive(1'b0, '0, '0, '0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4200 || count !== 2'd1) begin
            n_fail++;
            $display("FAIL flush_next: valid=%b pc=%h count=%0d, required 1/4200/1", out_valid, out_pc, count);
        end
        out_ready = 1'b1; tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_pc === 32'h4180) begin
            n_fail++;
            $display("FAIL flush_drop: valid=%b pc=%h, required 0 and not 4180", out_valid, out_pc);
        end
    endtask

    task automatic test_payload();
        out_ready = 1'b0;
        drive(1'b1, $urandom, 32'h5000, 5'd0, 1'b0); tick();
        drive(1'b1, 32'h1000_FFFF, 32'h5004, 5'd4, 1'b1); tick();
        drive(1'b0, '0, '0, '0, 1'b0);
        out_ready = 1'b1; tick();
        n_checks++;
        if ({out_instr, out_pc, out_exc, out_bd} !== {32'h1000_FFFF, 32'h5004, 5'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL payload: got %h required %h", dut_head(), {32'h1000_FFFF, 32'h5004, 5'd4, 1'b1});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'hDDDD_0000, 32'h6000, 5'd9, 1'b1); tick();
        drive(1'b1, 32'hDDDD_0004, 32'h6004, 5'd0, 1'b0); tick();
        reset = 1'b0; flush = 1'b1;
        drive(1'b1, 32'hDDDD_0008, 32'h6008, 5'd0, 1'b0); tick();
        n_checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || dut_head() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: count=%0d valid=%b in_ready=%b head=%h, required 0/0/1/0", count, out_valid, in_ready, dut_head());
        end
        reset = 1'b1; flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            tick();
            n_checks++;
            if (dut_head() !== exp_head() || count !== 2'(exp_q.size())
                || out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() < 2)) begin
                n_fail++;
                $display("FAIL random_%0d: head=%h count=%0d valid=%b ready=%b, required head=%h count=%0d",
                         i, dut_head(), count, out_valid, in_ready, exp_head(), exp_q.size());
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        drive(1'b0, '0, '0, '0, 1'b0);
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_accept_pop();
        test_flush();
        test_payload();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
